div8_seq: RTL and testbench
===========================

# div8_seq

Sequential 8-bit unsigned restoring divider for the lab datapath, the inverse of the shift-add multiplier. It uses the same Run-button handshake and computes one quotient bit per clock. The partial-remainder/quotient register pair shifts left, which is the opposite direction from the multiplier's right-shifting accumulator. A Run press latches the operands, runs 8 trial-subtract iterations, and holds the result until Run is released.

## Interface
- No parameters; width fixed at 8.
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset; forces IDLE and clears all registers.
- Run  in  1  start request, sampled synchronously (already debounced upstream).
- Dividend  in  8  numerator; sampled only in LOAD.
- Divisor  in  8  denominator; sampled only in LOAD.
- Quotient  out  8  result quotient; registered.
- Remainder  out  8  result remainder; registered.
- DivByZero  out  1  set with the results when the latched Divisor == 0.
- Busy  out  1  high in LOAD, ITER and FIXUP.
- Done  out  1  high in DONE.

## Operation
- States: IDLE, LOAD, ITER, FIXUP (only with the macro), DONE.
- IDLE: Run==1 -> LOAD; otherwise stay.
- LOAD (1 cycle):
  - A (9-bit partial remainder) <= 0; Q <= Dividend; D <= Divisor; count <= 0.
  - -> ITER.
- ITER (exactly 8 cycles), each cycle:
  - Shift {A,Q} left by 1.
  - T = A_shifted - {1'b0,D}, 9-bit.
  - If T[8]==0: A <= T and Q[0] <= 1. Else A is unchanged (A_shifted) and Q[0] <= 0.
  - count increments each cycle; at count==7 -> DONE (or FIXUP with the macro).
- On entry to DONE:
  - Quotient <= Q; Remainder <= A[7:0]; DivByZero <= (D==0).
  - These output registers change at no other time except Reset.
- DONE: Done=1; stay while Run==1; Run==0 -> IDLE. Holding Run never restarts a divide.
- Divide by zero: the algorithm runs unmodified. Result is Quotient=0xFF, Remainder=Dividend, DivByZero=1, with normal latency.
- Run changes while Busy are ignored. If Run is already low on reaching DONE, Done is high for exactly 1 cycle.
- Dividend/Divisor changes after LOAD have no effect.

## Timing
- Reset values: state=IDLE; Quotient=0x00, Remainder=0x00, DivByZero=0, Busy=0, Done=0; internal A, Q, D, count cleared.
- Reset mid-operation aborts immediately and asynchronously. Outputs clear; the next Run starts a fresh divide.
- Cycle-level sequence (edge E0 samples Run=1 in IDLE):
  - E1 executes LOAD.
  - E2..E9 execute the 8 iterations.
  - The state is DONE after E9, so Done and valid results appear 9 edges after E0.
- Busy goes high after E0 and low after the last Busy state.
- Back-to-back divides: minimum 1 IDLE cycle between DONE and the next LOAD.

## Configuration
- SIGNED_DIV_EN defined: operands are two's complement.
  - LOAD latches |Dividend| and |Divisor| plus the sign bits.
  - An extra FIXUP cycle after ITER negates the quotient when the signs differ, and negates the remainder when the Dividend is negative.
  - Division truncates toward zero.
  - Latency becomes 10 edges.
  - -128 / -1 yields Quotient=0x80, Remainder=0x00.
  - With Divisor==0, FIXUP is skipped for the outputs: Quotient=0xFF, Remainder=the raw Dividend, DivByZero=1, and latency is still 10.
- SIGNED_DIV_EN undefined: unsigned only, no FIXUP state, latency 9.

## Test plan
- Unsigned 200/7 (0xC8/0x07) -> Quotient=0x1C, Remainder=0x04, Done high exactly 9 edges after Run is sampled, Busy high for edges 1-9.
- 0xFF/0x01 -> Quotient=0xFF, Remainder=0x00. 3/10 -> Quotient=0x00, Remainder=0x03.
- 5/0 -> Quotient=0xFF, Remainder=0x05, DivByZero=1. Next run 9/3 -> Quotient=0x03, Remainder=0x00, DivByZero=0.
- Reset during the 4th ITER cycle -> all outputs 0x00/0 immediately and state IDLE. Then 100/9 -> Quotient=0x0B, Remainder=0x01.
- Hold Run high for 30 cycles -> a single divide, Done stays high, results stable, operand changes during DONE have no effect. Drop Run -> IDLE next edge.
- SIGNED_DIV_EN: -7/2 (0xF9/0x02) -> Quotient=0xFD, Remainder=0xFF, Done after 10 edges. -128/-1 -> 0x80/0x00. 7/-2 -> Quotient=0xFD, Remainder=0x01.

Source files
------------

// File: rtl/div8_seq.sv
// Sequential 8-bit restoring divider: Run handshake, one quotient bit per clock.
// Define SIGNED_DIV_EN for two's-complement operands with a sign-fixup cycle.
module div8_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       div_by_zero,
    output logic       busy,
    output logic       done
);

`ifdef SIGNED_DIV_EN
    typedef enum logic [2:0] {StIdle, StLoad, StIter, StFixup, StDone} state_t;
`else
    typedef enum logic [2:0] {StIdle, StLoad, StIter, StDone} state_t;
`endif

    state_t     state;
    // Partial remainder is always below the divisor between iterations, so 8 bits
    // hold it; the 9-bit shifted value and trial difference carry the extra bit.
    logic [7:0] a;
    logic [7:0] q;
    logic [7:0] d;
    logic [2:0] count;

`ifdef SIGNED_DIV_EN
    logic       neg_q;
    logic       neg_r;
`endif

    logic [8:0] a_sh;
    logic [8:0] t;
    logic [7:0] a_nx;
    logic [7:0] q_nx;

    always_comb begin
        a_sh = {a, q[7]};
        t    = a_sh - {1'b0, d};
        a_nx = t[8] ? a_sh[7:0] : t[7:0];
        q_nx = {q[6:0], ~t[8]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            a           <= 8'h00;
            q           <= 8'h00;
            d           <= 8'h00;
            count       <= 3'd0;
            quotient    <= 8'h00;
            remainder   <= 8'h00;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (run) begin
                        state <= StLoad;
                        busy  <= 1'b1;
                    end
                end
                StLoad: begin
                    a     <= 8'h00;
                    count <= 3'd0;
`ifdef SIGNED_DIV_EN
                    q     <= dividend[7] ? (8'd0 - dividend) : dividend;
                    d     <= divisor[7] ? (8'd0 - divisor) : divisor;
                    neg_q <= dividend[7] ^ divisor[7];
                    neg_r <= dividend[7];
`else
                    q     <= dividend;
                    d     <= divisor;
`endif
                    state <= StIter;
                end
                StIter: begin
                    a     <= a_nx;
                    q     <= q_nx;
                    count <= count + 3'd1;
                    if (count == 3'd7) begin
`ifdef SIGNED_DIV_EN
                        state <= StFixup;
`else
                        state       <= StDone;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_nx;
                        remainder   <= a_nx;
                        div_by_zero <= (d == 8'h00);
`endif
                    end
                end
`ifdef SIGNED_DIV_EN
                StFixup: begin
                    state       <= StDone;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= (d == 8'h00);
                    // A zero divisor reports the raw all-ones quotient unsigned.
                    quotient    <= (neg_q && (d != 8'h00)) ? (8'd0 - q) : q;
                    remainder   <= neg_r ? (8'd0 - a) : a;
                end
`endif
                StDone: begin
                    if (!run) begin
                        state <= StIdle;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div8_seq.sv
// Directed self-checking bench for div8_seq; build with SIGNED_DIV_EN to cover
// the signed configuration.
module tb_div8_seq;

`ifdef SIGNED_DIV_EN
    localparam int Lat = 10;
`else
    localparam int Lat = 9;
`endif

    logic       clk;
    logic       reset;
    logic       run;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    logic       busy;
    logic       done;

    int vectors;
    int miscompares;

    div8_seq dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts a divide, drops Run after E0 and scrambles operands after LOAD.
    // Reports latency, Busy correctness, results, and Done one edge later.
    task automatic do_div(input logic [7:0] dvd, input logic [7:0] dvs,
                          output int lat, output bit busy_ok,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic dbz, output logic done_after);
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        run      = 1'b1;
        @(posedge clk);
        #1;
        run     = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!done && lat < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                dividend = ~dvd;
                divisor  = dvs ^ 8'h5A;
            end
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
        q   = quotient;
        r   = remainder;
        dbz = div_by_zero;
        @(posedge clk);
        #1;
        done_after = done;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        run      = 1'b0;
        dividend = 8'h00;
        divisor  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({quotient, remainder} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_results got %h/%h want 00/00", quotient, remainder);
        end
        vectors++;
        if ({div_by_zero, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags got dbz=%b busy=%b done=%b want 000",
                     div_by_zero, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Applies a directed vector and compares every observed aspect.
    task automatic test_vector(input string name, input logic [7:0] dvd,
                               input logic [7:0] dvs, input logic [7:0] eq,
                               input logic [7:0] er, input logic edbz);
        int         lat;
        bit         busy_ok;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       done_after;
        do_div(dvd, dvs, lat, busy_ok, q, r, dbz, done_after);
        vectors++;
        if (lat !== Lat) begin
            miscompares++;
            $display("FAIL %s latency got %0d want %0d", name, lat, Lat);
        end
        vectors++;
        if (busy_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_window got bad want busy high until done", name);
        end
        vectors++;
        if ({q, r} !== {eq, er}) begin
            miscompares++;
            $display("FAIL %s result got %h/%h want %h/%h", name, q, r, eq, er);
        end
        vectors++;
        if (dbz !== edbz) begin
            miscompares++;
            $display("FAIL %s div_by_zero got %b want %b", name, dbz, edbz);
        end
        vectors++;
        if (done_after !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_pulse got done=%b after one cycle want 0", name, done_after);
        end
    endtask

    task automatic test_unsigned();
`ifdef SIGNED_DIV_EN
        test_vector("m56_div_7", 8'hC8, 8'h07, 8'hF8, 8'h00, 1'b0);
`else
        test_vector("200_div_7", 8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0);
`endif
        test_vector("ff_div_1", 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0);
        test_vector("3_div_10", 8'h03, 8'h0A, 8'h00, 8'h03, 1'b0);
    endtask

    task automatic test_div_by_zero();
        test_vector("5_div_0", 8'h05, 8'h00, 8'hFF, 8'h05, 1'b1);
        test_vector("9_div_3", 8'h09, 8'h03, 8'h03, 8'h00, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        dividend = 8'h64;
        divisor  = 8'h09;
        run      = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({quotient, remainder} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mid_results got %h/%h want 00/00", quotient, remainder);
        end
        vectors++;
        if ({div_by_zero, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_mid_flags got dbz=%b busy=%b done=%b want 000",
                     div_by_zero, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        test_vector("100_div_9", 8'h64, 8'h09, 8'h0B, 8'h01, 1'b0);
    endtask

    task automatic test_hold_run();
        int         lat;
        logic [7:0] eq;
        logic [7:0] er;
        int         bad_state;
        int         bad_result;
`ifdef SIGNED_DIV_EN
        eq = 8'hF8;
        er = 8'h00;
`else
        eq = 8'h1C;
        er = 8'h04;
`endif
        @(negedge clk);
        dividend = 8'hC8;
        divisor  = 8'h07;
        run      = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (lat !== Lat) begin
            miscompares++;
            $display("FAIL hold_latency got %0d want %0d", lat, Lat);
        end
        bad_state  = 0;
        bad_result = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
            @(posedge clk);
            #1;
            if (done !== 1'b1 || busy !== 1'b0) bad_state++;
            if ({quotient, remainder} !== {eq, er}) bad_result++;
        end
        vectors++;
        if (bad_state !== 0) begin
            miscompares++;
            $display("FAIL hold_done got %0d bad cycles want 0 (done=%b busy=%b)",
                     bad_state, done, busy);
        end
        vectors++;
        if (bad_result !== 0) begin
            miscompares++;
            $display("FAIL hold_results got %0d bad cycles, last %h/%h want %h/%h",
                     bad_result, quotient, remainder, eq, er);
        end
        @(negedge clk);
        run = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL hold_release got done=%b busy=%b want 00", done, busy);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_no_restart got busy=%b want 0", busy);
        end
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        test_vector("m7_div_2", 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0);
        test_vector("m128_div_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
        test_vector("7_div_m2", 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0);
        test_vector("m5_div_0", 8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1);
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_unsigned();
        test_div_by_zero();
        test_reset_mid();
        test_hold_run();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
